serial_addsub: RTL and testbench

//  Parametrised multi-cycle add/subtract unit with Z/V/N flags; signed or unsigned per op.

---
 rtl/serial_addsub_if.sv | 28 ++
 rtl/serial_addsub.sv | 136 +++++++++++++
 tb/tb_serial_addsub.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/serial_addsub_if.sv
// Operand/result handshake bundle for serial_addsub.
// The issue side drives the operands and out_ready; the unit drives the result, flags and in_ready.
interface serial_addsub_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             op_sub;
    logic             op_sign;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             z;
    logic             v;
    logic             n;

    modport master (
        output in_valid, a, b, op_sub, op_sign, out_ready,
        input  in_ready, out_valid, s, z, v, n
    );

    modport slave (
        input  in_valid, a, b, op_sub, op_sign, out_ready,
        output in_ready, out_valid, s, z, v, n
    );
endinterface

// File: rtl/serial_addsub.sv
// Multi-cycle add/subtract with Z/V/N flags. CHUNK bits are handled per cycle, and a
// registered carry links one chunk to the next.
module serial_addsub #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 8
) (
    input logic           clk,
    input logic           reset,
    serial_addsub_if.slave bus
);
    localparam int unsigned NCH = WIDTH / CHUNK;
    localparam int unsigned CW  = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, s_q, s_d;
    logic             sub_q, sub_d, sign_q, sign_d;
    logic             z_q, z_d, v_q, v_d, n_q, n_d;

    logic [CHUNK-1:0] a_chunk, b_chunk;
    logic [CHUNK:0]   sum;
    logic             last;
    logic             beff_msb;

    // Chunk select and one slice of the adder.
    always_comb begin
        a_chunk = '0;
        b_chunk = '0;
        for (int k = 0; k < NCH; k++) begin
            if (cnt_q == CW'(k)) begin
                a_chunk = a_q[k*CHUNK +: CHUNK];
                b_chunk = b_q[k*CHUNK +: CHUNK];
            end
        end
        sum      = {1'b0, a_chunk} + {1'b0, b_chunk ^ {CHUNK{sub_q}}} + {{CHUNK{1'b0}}, carry_q};
        last     = (cnt_q == CW'(NCH - 1));
        beff_msb = b_q[WIDTH-1] ^ sub_q;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sub_d   = sub_q;
        sign_d  = sign_q;
        s_d     = s_q;
        z_d     = z_q;
        v_d     = v_q;
        n_d     = n_q;
        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    sub_d   = bus.op_sub;
                    sign_d  = bus.op_sign;
                    carry_d = bus.op_sub;
                    cnt_d   = '0;
                    state_d = StCalc;
                end
            end
            StCalc: begin
                for (int k = 0; k < NCH; k++) begin
                    if (cnt_q == CW'(k)) begin
                        s_d[k*CHUNK +: CHUNK] = sum[CHUNK-1:0];
                    end
                end
                carry_d = sum[CHUNK];
                if (last) begin
                    cnt_d   = '0;
                    state_d = StDone;
                    z_d     = (s_d == '0);
                    // The MSB-chunk carry only feeds the flags; it never wraps to chunk 0.
                    if (sign_q) begin
                        v_d = (a_q[WIDTH-1] == beff_msb) && (s_d[WIDTH-1] != a_q[WIDTH-1]);
                        n_d = s_d[WIDTH-1] ^ v_d;
                    end else if (sub_q) begin
                        v_d = ~sum[CHUNK];
                        n_d = ~sum[CHUNK];
                    end else begin
                        v_d = sum[CHUNK];
                        n_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            StDone: begin
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sub_q   <= 1'b0;
            sign_q  <= 1'b0;
            s_q     <= '0;
            z_q     <= 1'b0;
            v_q     <= 1'b0;
            n_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sub_q   <= sub_d;
            sign_q  <= sign_d;
            s_q     <= s_d;
            z_q     <= z_d;
            v_q     <= v_d;
            n_q     <= n_d;
        end
    end

    assign bus.in_ready  = (state_q == StIdle);
    assign bus.out_valid = (state_q == StDone);
    assign bus.s         = s_q;
    assign bus.z         = z_q;
    assign bus.v         = v_q;
    assign bus.n         = n_q;
endmodule

// File: tb/tb_serial_addsub.sv
// Drives the same operand stream into CHUNK=8, 32 and 1 builds, then checks results,
// flags, latency, backpressure and async reset.
module tb_serial_addsub;
    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, op_sub, op_sign, out_ready;
    logic [31:0] a, b;

    int n_checks = 0;
    int n_pass   = 0;

    serial_addsub_if #(.WIDTH(32)) bus8 ();
    serial_addsub_if #(.WIDTH(32)) bus32 ();
    serial_addsub_if #(.WIDTH(32)) bus1 ();

    assign bus8.in_valid  = in_valid;
    assign bus8.a         = a;
    assign bus8.b         = b;
    assign bus8.op_sub    = op_sub;
    assign bus8.op_sign   = op_sign;
    assign bus8.out_ready = out_ready;
    assign bus32.in_valid  = in_valid;
    assign bus32.a         = a;
    assign bus32.b         = b;
    assign bus32.op_sub    = op_sub;
    assign bus32.op_sign   = op_sign;
    assign bus32.out_ready = out_ready;
    assign bus1.in_valid  = in_valid;
    assign bus1.a         = a;
    assign bus1.b         = b;
    assign bus1.op_sub    = op_sub;
    assign bus1.op_sign   = op_sign;
    assign bus1.out_ready = out_ready;

    serial_addsub #(.WIDTH(32), .CHUNK(8))  dut8  (.clk(clk), .reset(reset), .bus(bus8));
    serial_addsub #(.WIDTH(32), .CHUNK(32)) dut32 (.clk(clk), .reset(reset), .bus(bus32));
    serial_addsub #(.WIDTH(32), .CHUNK(1))  dut1  (.clk(clk), .reset(reset), .bus(bus1));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Spec-level reference: flags from the exact, unwrapped result.
    function automatic logic [34:0] model(input logic [31:0] ma, input logic [31:0] mb,
                                          input logic sub, input logic sign);
        logic [31:0] rs;
        logic [32:0] wide;
        longint      t;
        logic        mz, mv, mn;
        rs = sub ? ma - mb : ma + mb;
        mz = (rs == 32'd0);
        if (sign) begin
            t  = sub ? longint'($signed(ma)) - longint'($signed(mb))
                     : longint'($signed(ma)) + longint'($signed(mb));
            mv = (t > 64'sd2147483647) || (t < -64'sd2147483648);
            mn = (t < 0);
        end else if (sub) begin
            mv = (ma < mb);
            mn = (ma < mb);
        end else begin
            wide = {1'b0, ma} + {1'b0, mb};
            mv   = wide[32];
            mn   = 1'b0;
        end
        return {rs, mz, mv, mn};
    endfunction

    // Called #1 after a rising edge; the next edge accepts the op.
    task automatic start(input logic [31:0] ta, input logic [31:0] tb, input logic sub,
                         input logic sign);
        a        = ta;
        b        = tb;
        op_sub   = sub;
        op_sign  = sign;
        in_valid = 1'b1;
        check("in_ready before accept", 64'(bus8.in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Waits for all three builds to finish, then checks latency, sum and flags.
    task automatic finish_check(input string tag, input logic [34:0] exp);
        int lat8 = 0, lat32 = 0, lat1 = 0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(posedge clk);
            #1;
            if (bus8.out_valid && lat8 == 0)   lat8 = cyc;
            if (bus32.out_valid && lat32 == 0) lat32 = cyc;
            if (bus1.out_valid && lat1 == 0)   lat1 = cyc;
            if (lat8 != 0 && lat32 != 0 && lat1 != 0) break;
        end
        check({tag, " lat8"},  64'(lat8),  64'd4);
        check({tag, " lat32"}, 64'(lat32), 64'd1);
        check({tag, " lat1"},  64'(lat1),  64'd32);
        check({tag, " s8"},     64'(bus8.s), 64'(exp[34:3]));
        check({tag, " zvn8"},   64'({bus8.z, bus8.v, bus8.n}), 64'(exp[2:0]));
        check({tag, " s32"},    64'(bus32.s), 64'(exp[34:3]));
        check({tag, " zvn32"},  64'({bus32.z, bus32.v, bus32.n}), 64'(exp[2:0]));
        check({tag, " s1"},     64'(bus1.s), 64'(exp[34:3]));
        check({tag, " zvn1"},   64'({bus1.z, bus1.v, bus1.n}), 64'(exp[2:0]));
    endtask

    task automatic release_out(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, " in_ready after release"}, 64'(bus8.in_ready), 64'd1);
        check({tag, " out_valid after release"}, 64'(bus8.out_valid), 64'd0);
    endtask

    task automatic do_op(input string tag, input logic [31:0] ta, input logic [31:0] tb,
                         input logic sub, input logic sign, input logic [34:0] exp);
        start(ta, tb, sub, sign);
        finish_check(tag, exp);
        release_out(tag);
    endtask

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        op_sub    = 1'b0;
        op_sign   = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset in_ready", 64'(bus8.in_ready), 64'd1);
        check("reset out_valid", 64'(bus8.out_valid), 64'd0);
        check("reset s", 64'(bus8.s), 64'd0);
        check("reset zvn", 64'({bus8.z, bus8.v, bus8.n}), 64'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Expected {s, z, v, n} worked out by hand.
        do_op("usub 5-5",     32'd5,          32'd5, 1'b1, 1'b0, {32'h0000_0000, 3'b100});
        do_op("usub 3-5",     32'd3,          32'd5, 1'b1, 1'b0, {32'hFFFF_FFFE, 3'b011});
        do_op("uadd ff+1",    32'hFFFF_FFFF,  32'd1, 1'b0, 1'b0, {32'h0000_0000, 3'b110});
        do_op("ssub min-1",   32'h8000_0000,  32'd1, 1'b1, 1'b1, {32'h7FFF_FFFF, 3'b011});
        do_op("sadd max+1",   32'h7FFF_FFFF,  32'd1, 1'b0, 1'b1, {32'h8000_0000, 3'b010});

        // Backpressure: result held, new operands ignored.
        start(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
        finish_check("bp", {32'h2345_6789, 3'b000});
        a        = 32'hDEAD_BEEF;
        b        = 32'h0000_0001;
        op_sub   = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("bp s held", 64'(bus8.s), 64'h2345_6789);
            check("bp in_ready", 64'(bus8.in_ready), 64'd0);
            check("bp out_valid", 64'(bus8.out_valid), 64'd1);
        end
        check("bp zvn held", 64'({bus8.z, bus8.v, bus8.n}), 64'd0);
        in_valid = 1'b0;
        release_out("bp");
        do_op("ssub 5-7", 32'd5, 32'd7, 1'b1, 1'b1, {32'hFFFF_FFFE, 3'b001});

        // Async reset two cycles into CALC.
        start(32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("rst mid out_valid", 64'(bus8.out_valid), 64'd0);
        check("rst mid in_ready", 64'(bus8.in_ready), 64'd1);
        check("rst mid s", 64'(bus8.s), 64'd0);
        check("rst mid zvn", 64'({bus8.z, bus8.v, bus8.n}), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        do_op("ssub -7-(-7)", 32'hFFFF_FFF9, 32'hFFFF_FFF9, 1'b1, 1'b1, {32'h0000_0000, 3'b100});

        for (int i = 0; i < 12; i++) begin
            logic [31:0] ra, rb;
            logic        rsub, rsign;
            ra    = $urandom;
            rb    = (i % 4 == 0) ? ra : $urandom;
            rsub  = 1'($urandom_range(0, 1));
            rsign = 1'($urandom_range(0, 1));
            do_op("rand", ra, rb, rsub, rsign, model(ra, rb, rsub, rsign));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
